// File: rtl/modmul997_pkg.sv
// Shared constants and state encoding for the mod-997 sequential multiplier.
package modmul997_pkg;
    localparam int MODULUS = 997;
    localparam int W       = 10;
    localparam int DIGIT   = 3;
    localparam int ND      = 4;
    localparam int OP_W    = ND * DIGIT;
    localparam int ACC_W   = 24;

    typedef enum logic [1:0] {IDLE, MULT, REDUCE, DONE} state_t;
endpackage

// File: rtl/modmul997_seq_ctrl_if.sv
// Operand/result handshake bundle between scheduler, multiplier and consumer.
interface modmul997_seq_ctrl_if import modmul997_pkg::*;;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_res;
    logic         out_err;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_res, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_res, out_err
    );
endinterface

// File: rtl/mod_digit_mult_3x3.sv
// Combinational 3-bit x 3-bit unsigned digit multiplier shared by all partial products.
module mod_digit_mult_3x3 import modmul997_pkg::*; (
    input  logic [DIGIT-1:0]   x,
    input  logic [DIGIT-1:0]   y,
    output logic [2*DIGIT-1:0] p
);
    assign p = {{DIGIT{1'b0}}, x} * {{DIGIT{1'b0}}, y};
endmodule

// File: rtl/modmul997_seq_ctrl.sv
// Sequential (A*B) mod 997: 16 digit-product accumulate steps, 10 restoring-subtract steps, writeback.
// Optional operand range check enabled by defining MODMUL997_OPERAND_CHECK_EN.
module modmul997_seq_ctrl import modmul997_pkg::*; (
    input logic                 clk,
    input logic                 rst_n,
    modmul997_seq_ctrl_if.slave bus
);
    state_t            state;
    logic [OP_W-1:0]   a_q;
    logic [OP_W-1:0]   b_q;
    logic [ACC_W-1:0]  acc;
    logic [3:0]        cnt;
    logic              err_q;

    logic [DIGIT-1:0]   a_dig;
    logic [DIGIT-1:0]   b_dig;
    logic [2*DIGIT-1:0] pp;
    logic [ACC_W-1:0]   pp_term;
    logic [ACC_W-1:0]   sub_val;
    logic [3:0]         k;
    logic               op_bad;

`ifdef MODMUL997_OPERAND_CHECK_EN
    assign op_bad = (int'(bus.in_a) >= MODULUS) || (int'(bus.in_b) >= MODULUS);
`else
    assign op_bad = 1'b0;
`endif

    // In MULT, cnt[3:2] picks the A digit and cnt[1:0] the B digit; in REDUCE cnt counts steps up, k=9..0.
    always_comb begin
        a_dig   = a_q[DIGIT*int'(cnt[3:2]) +: DIGIT];
        b_dig   = b_q[DIGIT*int'(cnt[1:0]) +: DIGIT];
        pp_term = ACC_W'(pp) << (DIGIT * (int'(cnt[3:2]) + int'(cnt[1:0])));
        k       = 4'(W - 1) - cnt;
        sub_val = ACC_W'(MODULUS) << k;
    end

    mod_digit_mult_3x3 u_digit_mult (
        .x (a_dig),
        .y (b_dig),
        .p (pp)
    );

    // NOTE: all state updates use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_res   <= '0;
            bus.out_err   <= 1'b0;
            acc           <= '0;
            cnt           <= '0;
            a_q           <= '0;
            b_q           <= '0;
            err_q         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q          <= OP_W'(bus.in_a);
                        b_q          <= OP_W'(bus.in_b);
                        acc          <= '0;
                        err_q        <= op_bad;
                        bus.in_ready <= 1'b0;
                        // A rejected pair skips straight to the writeback step with acc=0.
                        if (op_bad) begin
                            state <= REDUCE;
                            cnt   <= 4'(W);
                        end else begin
                            state <= MULT;
                            cnt   <= '0;
                        end
                    end
                end
                MULT: begin
                    acc <= acc + pp_term;
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) state <= REDUCE;
                end
                REDUCE: begin
                    if (cnt == 4'(W)) begin
                        bus.out_res   <= acc[W-1:0];
                        bus.out_err   <= err_q;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        if (acc >= sub_val) acc <= acc - sub_val;
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        cnt           <= '0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_modmul997_seq_ctrl.sv
// Scoreboard bench for modmul997_seq_ctrl: driver pushes model results, monitor pops on each result.
module tb_modmul997_seq_ctrl;
    typedef struct {
        logic [9:0] res;
        logic       err;
        bit         chk_res;
        int         due;
        int         hold;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    exp_t sb[$];

    modmul997_seq_ctrl_if bus ();

    modmul997_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Issue one operand pair once the block is idle and queue the reference result.
    task automatic issue(input logic [9:0] a, input logic [9:0] b, input int hold, input bit junk);
        exp_t e;
        bit   ok = 1'b0;
        int   lat;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept_wait", 32'(ok), 32'd1);
        e.res     = 10'((int'(a) * int'(b)) % 997);
        e.err     = 1'b0;
        e.chk_res = 1'b1;
        lat       = 27;
`ifdef MODMUL997_OPERAND_CHECK_EN
        if (a >= 10'd997 || b >= 10'd997) begin
            e.res = 10'd0;
            e.err = 1'b1;
            lat   = 1;
        end
`else
        if (a >= 10'd997 || b >= 10'd997) e.chk_res = 1'b0;
`endif
        e.due  = cyc + 1 + lat;
        e.hold = hold;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (junk) begin
            for (int i = 0; i < 10; i++) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.in_a     = 10'($urandom);
                bus.in_b     = 10'($urandom);
                @(negedge clk);
            end
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && bus.out_valid === 1'b0 && bus.in_ready === 1'b1) begin
                done = 1'b1;
                break;
            end
        end
        check("drain_timeout", 32'(done), 32'd1);
    endtask

    // Monitor: owns out_ready, compares each presented result and its hold behaviour.
    initial begin
        exp_t       e;
        bit         seen = 1'b0;
        int         wait_left = 0;
        logic [9:0] held_res = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0;
            end else if (bus.out_valid === 1'b1) begin
                if (!seen) begin
                    seen     = 1'b1;
                    held_res = bus.out_res;
                    if (sb.size() == 0) begin
                        check("unexpected_valid", 32'(bus.out_valid), 32'd0);
                        wait_left = 0;
                    end else begin
                        e = sb.pop_front();
                        if (e.chk_res) check("out_res", 32'(bus.out_res), 32'(e.res));
                        check("out_err", 32'(bus.out_err), 32'(e.err));
                        check("latency_cycle", 32'(cyc), 32'(e.due));
                        wait_left = e.hold;
                    end
                end else begin
                    check("hold_res", 32'(bus.out_res), 32'(held_res));
                    check("hold_in_ready", 32'(bus.in_ready), 32'd0);
                end
                if (wait_left > 0) begin
                    wait_left--;
                    bus.out_ready = 1'b0;
                end else begin
                    bus.out_ready = 1'b1;
                end
            end else begin
                if (seen) begin
                    check("idle_after_accept", 32'(bus.in_ready), 32'd1);
                    seen = 1'b0;
                end
                bus.out_ready = (sb.size() == 0) ? 1'b1 : (sb[0].hold == 0);
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_res", 32'(bus.out_res), 32'd0);
        check("rst_out_err", 32'(bus.out_err), 32'd0);
        rst_n = 1'b1;

        issue(10'd123, 10'd456, 0, 1'b0); wait_idle();
        issue(10'd996, 10'd996, 0, 1'b0); wait_idle();
        issue(10'd2,   10'd500, 0, 1'b0); wait_idle();
        issue(10'd0,   10'd777, 0, 1'b0); wait_idle();
        issue(10'd123, 10'd456, 5, 1'b0); wait_idle();
        issue(10'd321, 10'd654, 0, 1'b1); wait_idle();

        // Abort an operation with a one-cycle reset while cnt==7.
        @(negedge clk);
        bus.in_a     = 10'd300;
        bus.in_b     = 10'd700;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_out_res", 32'(bus.out_res), 32'd0);
        issue(10'd10, 10'd10, 0, 1'b0); wait_idle();

        issue(10'd997, 10'd5, 0, 1'b0); wait_idle();
        issue(10'd1023, 10'd1023, 2, 1'b0); wait_idle();

        for (int n = 0; n < 20; n++) begin
            issue(10'($urandom_range(0, 996)), 10'($urandom_range(0, 996)),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            wait_idle();
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
